// File: rtl/multi_channel_divider_if.sv
// -----------------------------------------------------------------------------
// multi_channel_divider_if
//
// Control and output bundle of the multi-channel clock divider.
//
//   enable   global run enable
//   ch_en    per-channel run enable
//   div_n    new divide ratios, channel i in bits [i*WIDTH +: WIDTH]
//   load     per-channel one-cycle pulse, captures a ratio into the shadow
//   sync     one-cycle pulse, restarts every running channel at period start
//   pending  per-channel: shadow captured but not yet active
//   div_clk  per-channel divided clock
//   tick     per-channel one-cycle pulse in the cycle div_clk rises
//
// master : the controlling side (drives enable/ch_en/div_n/load/sync)
// slave  : the divider itself
// -----------------------------------------------------------------------------
interface multi_channel_divider_if #(
   parameter int CH    = 4,
   parameter int WIDTH = 8
);
   logic                  enable;
   logic [CH-1:0]         ch_en;
   logic [CH*WIDTH-1:0]   div_n;
   logic [CH-1:0]         load;
   logic                  sync;
   logic [CH-1:0]         pending;
   logic [CH-1:0]         div_clk;
   logic [CH-1:0]         tick;

   modport master (
      output enable, ch_en, div_n, load, sync,
      input  pending, div_clk, tick
   );

   modport slave (
      input  enable, ch_en, div_n, load, sync,
      output pending, div_clk, tick
   );
endinterface

// File: rtl/multi_channel_divider.sv
// -----------------------------------------------------------------------------
// multi_channel_divider
//
// Generates CH independent divided clocks from ref_clk. Each channel has an
// active ratio A, a shadow ratio written by load[i], and a counter cnt that
// runs 0..A-1. A new ratio only takes effect at a period start (natural wrap,
// sync, start of a run) or immediately while the channel is idle, so no runt
// pulses are produced. div_clk is high for cnt < ceil(A/2); tick marks cnt==0.
//
// Ports:
//   ref_clk  reference clock, all state on its rising edge
//   reset    asynchronous, active-low reset
//   bus      multi_channel_divider_if.slave (enable, ch_en, div_n, load, sync
//            in; pending, div_clk, tick out)
//
// Optional feature macro: ODD_DUTY50_EN
//   When defined, odd ratios A >= 3 get 50% duty: the posedge high phase is
//   shortened to (A-1)/2 cycles and a negedge copy of it, ORed in, stretches
//   the high phase by half a ref_clk period. Rising edges stay on posedge.
//   When undefined there is no negedge logic and odd duty is (A+1)/2:(A-1)/2.
// -----------------------------------------------------------------------------
module multi_channel_divider #(
   parameter int CH    = 4,
   parameter int WIDTH = 8
) (
   input  logic                    ref_clk,
   input  logic                    reset,
   multi_channel_divider_if.slave  bus
);

   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
   localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);

   logic [CH-1:0] pending_v;
   logic [CH-1:0] div_clk_v;
   logic [CH-1:0] tick_v;

   for (genvar g = 0; g < CH; g++) begin : g_ch
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic [WIDTH-1:0] act_q, act_d;
      logic [WIDTH-1:0] shadow_q, shadow_d;
      logic             pending_q, pending_d;
      logic             live_q, live_d;     // outputs were active last cycle
      logic             div_q, div_d;
      logic             tick_q, tick_d;
      logic             run;
      logic             wrap;
      logic             restart;
      logic             apply;
      logic [WIDTH:0]   half_d;             // length of the posedge high phase
`ifdef ODD_DUTY50_EN
      logic             odd_q, odd_d;
      logic             neg_q;
`endif

      // NOTE: every signal written here gets a value on every path, starting
      // with an unconditional assignment, so no latch can be inferred.
      always_comb begin
         run     = bus.enable & bus.ch_en[g] & (act_q != '0);
         // cnt == A-1 evaluated one bit wider so A-1 never underflows
         wrap    = run & live_q & (({1'b0, cnt_q} + ONE_X) == {1'b0, act_q});
         // a fresh period begins on a run start, a sync, or a natural wrap
         restart = run & (~live_q | bus.sync | wrap);
         apply   = pending_q & (~run | restart);

         act_d   = apply ? shadow_q : act_q;
         cnt_d   = (~run | restart) ? '0 : cnt_q + ONE_W;
         // a zero ratio taking effect at a boundary silences the channel at once
         live_d  = run & (act_d != '0);

         half_d  = ({1'b0, act_d} + ONE_X) >> 1;
`ifdef ODD_DUTY50_EN
         odd_d   = live_d & act_d[0] & ({1'b0, act_d} >= (WIDTH+1)'(3));
         if (odd_d) begin
            half_d = {1'b0, act_d} >> 1;
         end
`endif
         div_d   = live_d & ({1'b0, cnt_d} < half_d);
         tick_d  = live_d & (cnt_d == '0);

         // the old shadow is applied before a same-edge load overwrites it
         shadow_d  = bus.load[g] ? bus.div_n[g*WIDTH +: WIDTH] : shadow_q;
         pending_d = bus.load[g] | (pending_q & ~apply);
      end

      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values computed above.
      always_ff @(posedge ref_clk or negedge reset) begin
         if (!reset) begin
            cnt_q     <= '0;
            act_q     <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            live_q    <= 1'b0;
            div_q     <= 1'b0;
            tick_q    <= 1'b0;
         end else begin
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            live_q    <= live_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
         end
      end

`ifdef ODD_DUTY50_EN
      always_ff @(posedge ref_clk or negedge reset) begin
         if (!reset) begin
            odd_q <= 1'b0;
         end else begin
            odd_q <= odd_d;
         end
      end

      // half-cycle delayed copy of the high phase, only for odd A >= 3
      always_ff @(negedge ref_clk or negedge reset) begin
         if (!reset) begin
            neg_q <= 1'b0;
         end else begin
            neg_q <= div_q & odd_q;
         end
      end

      assign div_clk_v[g] = div_q | neg_q;
`else
      assign div_clk_v[g] = div_q;
`endif
      assign pending_v[g] = pending_q;
      assign tick_v[g]    = tick_q;
   end

   assign bus.pending = pending_v;
   assign bus.div_clk = div_clk_v;
   assign bus.tick    = tick_v;

endmodule
